// File: rtl/memory_ctrl_pkg.sv
// Shared definitions for the memory controller slice.
//   state_t        : controller FSM states
//   Def*           : default address width, depth and data width
//   MaxWaitStates  : largest supported WaitStates value (wait counter range)
//   addr_idx_w()   : index width needed to address a given number of words
package memory_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  localparam int unsigned DefAddrBusSize = 16;
  localparam int unsigned DefNumElements = 65536;
  localparam int unsigned DefElementSize = 16;
  localparam int unsigned MaxWaitStates  = 15;
  localparam int unsigned WaitCntW       = 4;

  function automatic int unsigned addr_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_ctrl_if.sv
// Request/response bus between a requester (master) and memory_ctrl (slave).
//   i_req, i_we, i_addr, i_wdata : request fields, driven by the master
//   o_busy, o_ready, o_err, o_rdata : status and read data, driven by the slave
interface memory_ctrl_if
  import memory_ctrl_pkg::*;
#(
  parameter int unsigned AddrBusSize = DefAddrBusSize,
  parameter int unsigned ElementSize = DefElementSize
);

  logic                   i_req;
  logic                   i_we;
  logic [AddrBusSize-1:0] i_addr;
  logic [ElementSize-1:0] i_wdata;
  logic                   o_busy;
  logic                   o_ready;
  logic                   o_err;
  logic [ElementSize-1:0] o_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_busy, o_ready, o_err, o_rdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_busy, o_ready, o_err, o_rdata
  );

endinterface

// File: rtl/memory_ctrl_ram_array.sv
// Single-port synchronous RAM: one write port and one registered read port
// sharing an address. Contents are never cleared by reset.
//   i_CLK  : clock
//   we     : write enable, commits wdata at addr
//   re     : read enable, updates rdata from addr
//   addr   : word address (only the low bits needed for NumElements are used)
//   wdata  : write data
//   rdata  : registered read data, held while re is low
module ram_array
  import memory_ctrl_pkg::*;
#(
  parameter              INIT_FILE   = "",
  parameter int unsigned AddrBusSize = DefAddrBusSize,
  parameter int unsigned NumElements = DefNumElements,
  parameter int unsigned ElementSize = DefElementSize
) (
  input  logic                   i_CLK,
  input  logic                   we,
  input  logic                   re,
  input  logic [AddrBusSize-1:0] addr,
  input  logic [ElementSize-1:0] wdata,
  output logic [ElementSize-1:0] rdata
);

  localparam int unsigned IdxW = addr_idx_w(NumElements);

  logic [ElementSize-1:0] mem [NumElements];
  logic [IdxW-1:0]        idx;

  // Upper address bits are range-checked by the controller, not used here.
  logic unused_addr;
  assign unused_addr = ^addr;
  assign idx         = addr[IdxW-1:0];

  always_ff @(posedge i_CLK) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/memory_ctrl.sv
// Memory controller: accepts one request at a time in IDLE, optionally
// stalls WaitStates cycles, performs a single RAM access, then pulses
// o_ready (and o_err for out-of-range addresses) for one cycle.
//   i_CLK : clock, rising edge
//   i_RST : asynchronous active-high reset
//   bus   : request/response bus (slave side)
module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter              INIT_FILE   = "",
  parameter int unsigned AddrBusSize = DefAddrBusSize,
  parameter int unsigned NumElements = DefNumElements,
  parameter int unsigned ElementSize = DefElementSize,
  parameter int unsigned WaitStates  = 0
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  memory_ctrl_if.slave  bus
);

  localparam logic [WaitCntW-1:0] WaitLoad =
    WaitCntW'((WaitStates > 0) ? (WaitStates - 1) : 0);

  state_t                 state;
  logic [WaitCntW-1:0]    wait_cnt;
  logic                   req_we;
  logic [AddrBusSize-1:0] req_addr;
  logic [ElementSize-1:0] req_wdata;
  logic                   busy_q;
  logic                   ready_q;
  logic                   err_q;
  logic                   rd_valid_q;

  logic                   in_range;
  logic                   ram_we;
  logic                   ram_re;
  logic [ElementSize-1:0] ram_rdata;

  assign in_range = (64'(req_addr) < 64'(NumElements));
  assign ram_we   = (state == ACCESS) &&  req_we && in_range;
  assign ram_re   = (state == ACCESS) && !req_we && in_range;

  ram_array #(
    .INIT_FILE   (INIT_FILE),
    .AddrBusSize (AddrBusSize),
    .NumElements (NumElements),
    .ElementSize (ElementSize)
  ) u_ram (
    .i_CLK (i_CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            req_we    <= bus.i_we;
            req_addr  <= bus.i_addr;
            req_wdata <= bus.i_wdata;
            busy_q    <= 1'b1;
            if (WaitStates > 0) begin
              state    <= WAIT;
              wait_cnt <= WaitLoad;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= ACCESS;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ACCESS: begin
          state   <= DONE;
          ready_q <= 1'b1;
          err_q   <= !in_range;
          // Writes leave the read-data qualifier alone so o_rdata holds.
          if (!req_we) rd_valid_q <= in_range;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The RAM read register is not resettable (block-RAM friendly), so the
  // visible read data is qualified by a resettable flag: zero after reset
  // or after an out-of-range read, otherwise the last in-range read word.
  assign bus.o_busy  = busy_q;
  assign bus.o_ready = ready_q;
  assign bus.o_err   = err_q;
  assign bus.o_rdata = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_memory_ctrl.sv
module tb_memory_ctrl;

  logic        i_CLK;
  logic        i_RST;

  logic        req_v   [4];
  logic        we_v    [4];
  logic [15:0] addr_v  [4];
  logic [15:0] wdata_v [4];
  logic        busy_o  [4];
  logic        ready_o [4];
  logic        err_o   [4];
  logic [15:0] rdata_o [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: WaitStates=0, full depth
  // Instance 1: WaitStates=3
  // Instance 2: WaitStates=0, NumElements=512
  // Instance 3: WaitStates=2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    memory_ctrl_if bus ();
    assign bus.i_req   = req_v[g];
    assign bus.i_we    = we_v[g];
    assign bus.i_addr  = addr_v[g];
    assign bus.i_wdata = wdata_v[g];
    assign busy_o[g]   = bus.o_busy;
    assign ready_o[g]  = bus.o_ready;
    assign err_o[g]    = bus.o_err;
    assign rdata_o[g]  = bus.o_rdata;

    memory_ctrl #(
      .INIT_FILE   (""),
      .AddrBusSize (16),
      .NumElements ((g == 2) ? 512 : 65536),
      .ElementSize (16),
      .WaitStates  ((g == 1) ? 3 : ((g == 3) ? 2 : 0))
    ) dut (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .bus   (bus.slave)
    );
  end

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with instance d idle. Presents one request, scrambles
  // the request fields right after the sampling edge, and waits (bounded) for
  // o_ready. Latency counts rising edges, the sampling edge being the first.
  // Returns at the negedge after the DONE cycle.
  task automatic do_access(input int d, input logic we, input logic [15:0] a,
                           input logic [15:0] wd, input int exp_lat,
                           input logic exp_err, input logic chk_rd,
                           input logic [15:0] exp_rd, input string tag,
                           output int busy_n);
    int   lat;
    logic seen;
    lat    = 0;
    seen   = 1'b0;
    busy_n = 0;
    req_v[d]   = 1'b1;
    we_v[d]    = we;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge i_CLK);
      lat++;
      @(negedge i_CLK);
      if (lat == 1) begin
        req_v[d]   = 1'b0;
        we_v[d]    = ~we;
        addr_v[d]  = ~a;
        wdata_v[d] = ~wd;
      end
      if (busy_o[d])  busy_n++;
      if (ready_o[d]) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, seen ? lat : 0, exp_lat);
    check_eq({tag, "_err"}, {31'b0, err_o[d]}, {31'b0, exp_err});
    if (chk_rd) check_eq({tag, "_rdata"}, {16'b0, rdata_o[d]}, {16'b0, exp_rd});
    @(negedge i_CLK);
    check_eq({tag, "_idle"}, {30'b0, busy_o[d], ready_o[d]}, 32'h0);
  endtask

  initial begin
    int   bn;
    logic saw_ready;
    logic exp_r;
    for (int i = 0; i < 4; i++) begin
      req_v[i]   = 1'b0;
      we_v[i]    = 1'b0;
      addr_v[i]  = 16'h0;
      wdata_v[i] = 16'h0;
    end
    i_RST = 1'b1;
    repeat (3) @(negedge i_CLK);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("reset_out_%0d", i),
               {13'b0, busy_o[i], ready_o[i], err_o[i], rdata_o[i]}, 32'h0);
    i_RST = 1'b0;

    // WaitStates=0 write then read; first request right after reset release.
    do_access(0, 1'b1, 16'h0010, 16'h1234, 2, 1'b0, 1'b0, 16'h0,    "w10", bn);
    do_access(0, 1'b0, 16'h0010, 16'h0,    2, 1'b0, 1'b1, 16'h1234, "r10", bn);

    // o_rdata holds across a write completion.
    do_access(0, 1'b1, 16'h0030, 16'h5555, 2, 1'b0, 1'b0, 16'h0,    "w30", bn);
    do_access(0, 1'b0, 16'h0030, 16'h0,    2, 1'b0, 1'b1, 16'h5555, "r30", bn);
    do_access(0, 1'b1, 16'h0031, 16'h7777, 2, 1'b0, 1'b1, 16'h5555, "w31_hold", bn);
    do_access(0, 1'b0, 16'h0031, 16'h0,    2, 1'b0, 1'b1, 16'h7777, "r31", bn);

    // WaitStates=3: preload through the bus, then read with busy count.
    do_access(1, 1'b1, 16'h0000, 16'hF025, 5, 1'b0, 1'b0, 16'h0,    "w0_ws3", bn);
    do_access(1, 1'b1, 16'h0020, 16'h1111, 5, 1'b0, 1'b0, 16'h0,    "w20_ws3", bn);
    do_access(1, 1'b0, 16'h0000, 16'h0,    5, 1'b0, 1'b1, 16'hF025, "r0_ws3", bn);
    check_eq("r0_ws3_busy_cycles", bn, 5);

    // Reset during WAIT aborts a write.
    saw_ready   = 1'b0;
    req_v[1]    = 1'b1;
    we_v[1]     = 1'b1;
    addr_v[1]   = 16'h0020;
    wdata_v[1]  = 16'hAAAA;
    @(negedge i_CLK);
    req_v[1] = 1'b0;
    check_eq("abort_in_wait_busy", {31'b0, busy_o[1]}, 32'h1);
    saw_ready = ready_o[1];
    i_RST = 1'b1;
    #1;
    check_eq("abort_reset_out",
             {13'b0, busy_o[1], ready_o[1], err_o[1], rdata_o[1]}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_CLK);
      if (ready_o[1]) saw_ready = 1'b1;
      if (k == 2) i_RST = 1'b0;
    end
    check_eq("abort_no_ready", {31'b0, saw_ready}, 32'h0);
    check_eq("abort_rdata_zero", {16'b0, rdata_o[1]}, 32'h0);
    i_RST = 1'b1;
    @(negedge i_CLK);
    i_RST = 1'b0;
    do_access(1, 1'b0, 16'h0020, 16'h0, 5, 1'b0, 1'b1, 16'h1111, "r20_after_rst", bn);

    // NumElements=512: out-of-range write and read.
    do_access(2, 1'b1, 16'h0000, 16'h0BAD, 2, 1'b0, 1'b0, 16'h0,    "w0_small", bn);
    do_access(2, 1'b0, 16'h0000, 16'h0,    2, 1'b0, 1'b1, 16'h0BAD, "r0_small", bn);
    do_access(2, 1'b1, 16'h0200, 16'hBEEF, 2, 1'b1, 1'b1, 16'h0BAD, "w200_oor", bn);
    do_access(2, 1'b0, 16'h0200, 16'h0,    2, 1'b1, 1'b1, 16'h0000, "r200_oor", bn);
    do_access(2, 1'b0, 16'h0000, 16'h0,    2, 1'b0, 1'b1, 16'h0BAD, "r0_small_again", bn);

    // WaitStates=2: continuous requests, addresses alternating every cycle.
    do_access(3, 1'b1, 16'h0040, 16'h4040, 4, 1'b0, 1'b0, 16'h0, "w40_ws2", bn);
    do_access(3, 1'b1, 16'h0041, 16'h4141, 4, 1'b0, 1'b0, 16'h0, "w41_ws2", bn);
    for (int j = 0; j < 23; j++) begin
      if (j > 0) @(negedge i_CLK);
      exp_r = ((j % 5) == 4);
      check_eq($sformatf("stream_ready_%0d", j), {31'b0, ready_o[3]}, {31'b0, exp_r});
      if (exp_r)
        check_eq($sformatf("stream_rdata_%0d", j), {16'b0, rdata_o[3]},
                 (((j / 5) % 2) == 0) ? 32'h4040 : 32'h4141);
      req_v[3]  = 1'b1;
      we_v[3]   = 1'b0;
      addr_v[3] = ((j % 2) == 0) ? 16'h0040 : 16'h0041;
    end
    req_v[3] = 1'b0;
    for (int k = 0; k < 20 && busy_o[3]; k++) @(negedge i_CLK);
    check_eq("stream_drained", {31'b0, busy_o[3]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
